// File: rtl/tdc_frame_sched_if.sv
// Bus bundle between the frame scheduler, the TDC capture units, the multiply/sum tree
// and the host result port. The slave modport is the scheduler side.
interface tdc_frame_sched_if #(
    parameter int NCH = 8
);
    logic                  arm;
    logic [NCH-1:0]        ch_vld;
    logic [NCH-1:0][9:0]   ch_int;
    logic [NCH-1:0][6:0]   ch_frac;
    logic                  mlt_start;
    logic [NCH-1:0][9:0]   mlt_int;
    logic [NCH-1:0][6:0]   mlt_frac;
    logic [19:0]           mlt_sum;
    logic                  mlt_dval;
    logic [19:0]           res_data;
    logic [NCH-1:0]        res_miss;
    logic                  res_valid;
    logic                  res_ready;
    logic                  busy;
    logic [15:0]           drop_cnt;

    modport slave (
        input  arm, ch_vld, ch_int, ch_frac, mlt_sum, mlt_dval, res_ready,
        output mlt_start, mlt_int, mlt_frac, res_data, res_miss, res_valid, busy, drop_cnt
    );

    modport master (
        output arm, ch_vld, ch_int, ch_frac, mlt_sum, mlt_dval, res_ready,
        input  mlt_start, mlt_int, mlt_frac, res_data, res_miss, res_valid, busy, drop_cnt
    );
endinterface

// File: rtl/tdc_frame_sched.sv
// Frame sequencer for the coarse*50+fine tree: collects one hit per channel, launches the
// tree, averages 2^AVG_LOG2 sums. Define TDC_SCHED_DROP_CNT_EN to build the drop counter.
module tdc_frame_sched #(
    parameter int NCH      = 8,
    parameter int AVG_LOG2 = 4,
    parameter int TMO_CYC  = 1023
) (
    input  logic              clk,
    input  logic              rst,
    tdc_frame_sched_if.slave  bus
);
    localparam int ACC_W = 20 + AVG_LOG2;
    localparam int FC_W  = AVG_LOG2 + 1;
    localparam int TMR_W = $clog2(TMO_CYC + 1);
    localparam logic [FC_W-1:0]  FRAMES  = FC_W'(2 ** AVG_LOG2);
    localparam logic [TMR_W-1:0] TMR_END = TMR_W'(TMO_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COLLECT = 3'd1,
        S_LAUNCH  = 3'd2,
        S_WAIT    = 3'd3,
        S_OUT     = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [NCH-1:0]     r_hit;
    logic [NCH-1:0]     r_miss;
    logic [TMR_W-1:0]   r_tmr;
    logic [ACC_W-1:0]   r_acc;
    logic [FC_W-1:0]    r_fcnt;
    logic               r_start;
    logic               r_valid;
    logic [19:0]        r_res_data;
    logic [NCH-1:0]     r_res_miss;
    logic [9:0]         r_int  [NCH];
    logic [6:0]         r_frac [NCH];

    logic [NCH-1:0]     w_take;
    logic [NCH-1:0]     w_hit_next;
    logic               w_full;
    logic               w_tmo;
    logic               w_tmo_miss;
    logic               w_open;
    logic               w_frame_done;
    logic [ACC_W-1:0]   w_acc_sum;

    assign w_open       = (r_state == S_IDLE) && bus.arm;
    assign w_take       = bus.ch_vld & ~r_hit;
    assign w_hit_next   = r_hit | bus.ch_vld;
    assign w_full       = &w_hit_next;
    assign w_tmo        = (r_tmr == TMR_END);
    assign w_tmo_miss   = (r_state == S_COLLECT) && w_tmo && !w_full;
    assign w_frame_done = ((r_fcnt + 1'b1) == FRAMES);
    assign w_acc_sum    = r_acc + ACC_W'(bus.mlt_sum);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (bus.arm) w_state_next = S_COLLECT;
            S_COLLECT: if (w_full || w_tmo) w_state_next = S_LAUNCH;
            S_LAUNCH:  w_state_next = S_WAIT;
            S_WAIT:    if (bus.mlt_dval) w_state_next = w_frame_done ? S_OUT : S_IDLE;
            S_OUT:     if (bus.res_ready) w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    // Start and valid are registered from the next state so they align exactly with
    // LAUNCH and OUT without a decode glitch on the outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hit      <= '0;
            r_miss     <= '0;
            r_tmr      <= '0;
            r_acc      <= '0;
            r_fcnt     <= '0;
            r_start    <= 1'b0;
            r_valid    <= 1'b0;
            r_res_data <= '0;
            r_res_miss <= '0;
        end else begin
            r_start <= (w_state_next == S_LAUNCH);
            r_valid <= (w_state_next == S_OUT);
            case (r_state)
                S_IDLE: begin
                    if (bus.arm) begin
                        r_hit <= '0;
                        r_tmr <= '0;
                    end
                end
                S_COLLECT: begin
                    r_hit <= w_hit_next;
                    r_tmr <= r_tmr + 1'b1;
                    if (w_tmo && !w_full) r_miss <= r_miss | ~w_hit_next;
                end
                S_WAIT: begin
                    if (bus.mlt_dval) begin
                        r_acc  <= w_acc_sum;
                        r_fcnt <= r_fcnt + 1'b1;
                        if (w_frame_done) begin
                            r_res_data <= w_acc_sum[AVG_LOG2 +: 20];
                            r_res_miss <= r_miss;
                        end
                    end
                end
                S_OUT: begin
                    if (bus.res_ready) begin
                        r_acc  <= '0;
                        r_fcnt <= '0;
                        r_miss <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Per-channel latches: cleared when a window opens, first strobe in the window wins.
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_int[gi]  <= '0;
                r_frac[gi] <= '0;
            end else if (w_open) begin
                r_int[gi]  <= '0;
                r_frac[gi] <= '0;
            end else if ((r_state == S_COLLECT) && w_take[gi]) begin
                r_int[gi]  <= bus.ch_int[gi];
                r_frac[gi] <= bus.ch_frac[gi];
            end
        end
        assign bus.mlt_int[gi]  = r_int[gi];
        assign bus.mlt_frac[gi] = r_frac[gi];
    end

`ifdef TDC_SCHED_DROP_CNT_EN
    logic [15:0] r_drop;
    logic [1:0]  w_drop_inc;
    logic [16:0] w_drop_sum;

    // An ignored arm and a timeout can land on the same cycle, so the step can be 2.
    assign w_drop_inc = {1'b0, bus.arm && (r_state != S_IDLE)} + {1'b0, w_tmo_miss};
    assign w_drop_sum = {1'b0, r_drop} + 17'(w_drop_inc);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_drop <= '0;
        end else begin
            r_drop <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
        end
    end

    assign bus.drop_cnt = r_drop;
`else
    assign bus.drop_cnt = '0;
`endif

    assign bus.mlt_start = r_start;
    assign bus.res_valid = r_valid;
    assign bus.res_data  = r_res_data;
    assign bus.res_miss  = r_res_miss;
    assign bus.busy      = (r_state != S_IDLE);
endmodule
